// File: rtl/apb_master.sv
// APB3 requester: single read/write commands in, IDLE/SETUP/ACCESS sequence out, one-cycle response strobe.
// Optional PREADY timeout enabled by defining APB_MASTER_TIMEOUT_EN (limit set by TIMEOUT).
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              I_PCLK,
  input  logic              I_PRESET,
  input  logic              I_CMD_VALID,
  output logic              O_CMD_READY,
  input  logic              I_CMD_WRITE,
  input  logic [ADDR_W-1:0] I_CMD_ADDR,
  input  logic [DATA_W-1:0] I_CMD_WDATA,
  output logic              O_RSP_VALID,
  output logic [DATA_W-1:0] O_RSP_RDATA,
  output logic              O_RSP_ERR,
  output logic              O_PSEL,
  output logic              O_PENABLE,
  output logic              O_PWRITE,
  output logic [ADDR_W-1:0] O_PADDR,
  output logic [DATA_W-1:0] O_PWDATA,
  input  logic [DATA_W-1:0] I_PRDATA,
  input  logic              I_PREADY,
  input  logic              I_PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);
  // Holds the index of the current ACCESS cycle (1 on the first one).
  logic [15:0]         cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (I_CMD_VALID) begin
          pwrite_d = I_CMD_WRITE;
          paddr_d  = I_CMD_ADDR;
          pwdata_d = I_CMD_WDATA;
          state_d  = ST_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q + 16'd1;
`endif
      end
      ST_ACCESS: begin
        if (I_PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : I_PRDATA;
          rsp_err_d   = I_PSLVERR;
          state_d     = ST_IDLE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_L) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_PCLK or posedge I_PRESET) begin
    if (I_PRESET) begin
      state_q     <= ST_IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Decoded straight from the state register so reset drops PSEL/PENABLE without waiting for a clock.
  assign O_CMD_READY = (state_q == ST_IDLE);
  assign O_PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign O_PENABLE   = (state_q == ST_ACCESS);
  assign O_PWRITE    = pwrite_q;
  assign O_PADDR     = paddr_q;
  assign O_PWDATA    = pwdata_q;
  assign O_RSP_VALID = rsp_valid_q;
  assign O_RSP_RDATA = rsp_rdata_q;
  assign O_RSP_ERR   = rsp_err_q;

endmodule

// File: doc/apb_master.md
# apb_master

Requester side of the APB link used by the rotate engine's register interface. Accepts single read/write commands from an internal command port, drives a compliant APB3 SETUP/ACCESS sequence to one slave, honours wait states via PREADY, and returns read data and error status on a one-cycle response strobe. Sits between the test/host-side controller and the register-block slave.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles waited for PREADY (used only with APB_MASTER_TIMEOUT_EN; legal 2..65535)

- I_PCLK  in  1  clock, all logic on rising edge
- I_PRESET  in  1  reset, asynchronous, active-high
- I_CMD_VALID  in  1  command request
- O_CMD_READY  out  1  command accepted when VALID&&READY
- I_CMD_WRITE  in  1  1 = write, 0 = read
- I_CMD_ADDR  in  ADDR_W  target address
- I_CMD_WDATA  in  DATA_W  write data
- O_RSP_VALID  out  1  one-cycle completion strobe
- O_RSP_RDATA  out  DATA_W  read data (0 for writes)
- O_RSP_ERR  out  1  PSLVERR or timeout on completed transfer
- O_PSEL, O_PENABLE, O_PWRITE  out  1  APB control
- O_PADDR  out  ADDR_W  APB address
- O_PWDATA  out  DATA_W  APB write data
- I_PRDATA  in  DATA_W  APB read data
- I_PREADY  in  1  slave ready
- I_PSLVERR  in  1  slave error, valid with PREADY

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: O_CMD_READY=1 (combinational, state==IDLE only). On VALID&&READY latch WRITE/ADDR/WDATA into O_PWRITE/O_PADDR/O_PWDATA; go SETUP.
- SETUP: O_PSEL=1, O_PENABLE=0; unconditionally go ACCESS.
- ACCESS: O_PSEL=1, O_PENABLE=1; stay while I_PREADY=0; on I_PREADY=1 capture I_PRDATA (reads only, writes capture 0) and I_PSLVERR, go IDLE.
- O_PADDR/O_PWRITE/O_PWDATA held stable from SETUP through last ACCESS cycle and retain value in IDLE until next accept.
- I_PSLVERR ignored when I_PREADY=0.
- No response backpressure; caller must consume O_RSP_VALID when pulsed.
- Reset: state=IDLE; O_PSEL, O_PENABLE, O_PWRITE, O_RSP_VALID, O_RSP_ERR=0; O_PADDR, O_PWDATA, O_RSP_RDATA=0. Assertion mid-transfer forces IDLE and drops PSEL/PENABLE immediately (asynchronously); no response issued for the aborted transfer.

## Timing
- Accept in cycle N → SETUP in N+1 → first ACCESS in N+2.
- PREADY high in first ACCESS (zero wait): O_RSP_VALID=1 in N+3, which is also IDLE with O_CMD_READY=1; a new command accepted in N+3 enters SETUP in N+4.
- Min throughput: one transfer per 3 cycles; each wait state adds one cycle.
- O_RSP_VALID high exactly one cycle; O_RSP_RDATA/O_RSP_ERR registered and held until next response.
- Response strobe and next command acceptance in the same cycle are legal and independent.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: counter counts ACCESS cycles (1 on first). If I_PREADY=0 on ACCESS cycle TIMEOUT, transfer aborts at end of that cycle: go IDLE, O_RSP_VALID=1 next cycle with O_RSP_ERR=1, O_RSP_RDATA=0. I_PREADY=1 on cycle TIMEOUT completes normally. Counter clears on entry to SETUP.
- Undefined: no counter; ACCESS waits indefinitely for I_PREADY.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010, PREADY tied 1 → SETUP/ACCESS one cycle each with PWRITE=1, PADDR=0x10, PWDATA=0xDEADBEEF; RSP_VALID 3 cycles after accept, RSP_ERR=0, RSP_RDATA=0.
- Read 0x0000_0004, PREADY low 3 ACCESS cycles, PRDATA=0x1234_5678 on ready → PSEL/PENABLE/PADDR stable 4 ACCESS cycles; RSP_RDATA=0x12345678 6 cycles after accept.
- Read with PSLVERR=1 while PREADY=0 then PSLVERR=1 with PREADY=1 → RSP_ERR=1 only from ready cycle; PSLVERR=1 with PREADY=0 alone never sets error.
- Back-to-back: VALID held high with 4 commands, PREADY=1 → accepts every 3 cycles, 4 RSP_VALID pulses, READY low in SETUP/ACCESS.
- I_PRESET asserted during ACCESS of a read → PSEL/PENABLE 0 same cycle, no RSP_VALID, READY=1 after release, next command proceeds normally.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT=4, PREADY stuck 0 → exactly 4 ACCESS cycles, then RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0; PREADY=1 on cycle 4 → normal completion, RSP_ERR=0.
